// File: rtl/pipe_adder_pkg.sv
// Shared constants and helpers for the pipelined ripple-slice adder.
// The slice width is derived once here so the top and any wrappers agree on it.
package pipe_adder_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_STAGES = 2;
    localparam int MIN_STAGES     = 1;
    localparam int MAX_STAGES     = 8;

    // Width of one carry slice; guarded so an illegal STAGES cannot divide by zero
    // before the elaboration check reports it.
    function automatic int slice_w(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

    function automatic logic stages_legal(input int width, input int stages);
        return (stages >= MIN_STAGES) && (stages <= MAX_STAGES) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit full adder used by each pipeline stage.
// Also reports the carry into its MSB so the last stage can form the overflow flag.
module adder_slice #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout,
    output logic         o_cmsb
);

    logic [W:0] w_total;

    assign w_total = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
    assign o_sum   = w_total[W-1:0];
    assign o_cout  = w_total[W];
    // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out directly.
    assign o_cmsb  = i_a[W-1] ^ i_b[W-1] ^ w_total[W-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor: one equal-width carry slice per stage, carry registered between stages.
// A single global stall freezes every stage while a finished result waits for the consumer.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SW = slice_w(WIDTH, STAGES);

    if (!stages_legal(WIDTH, STAGES)) begin : g_param_check
        $error("pipe_adder: STAGES must be in 1..8 and divide WIDTH exactly");
    end

    // Index 0 is the operand side; index k+1 is the register bank of stage k.
    logic             w_valid_pipe [STAGES+1];
    logic [WIDTH-1:0] w_sum_pipe   [STAGES+1];
    logic [WIDTH-1:0] w_a_pipe     [STAGES+1];
    logic [WIDTH-1:0] w_b_pipe     [STAGES+1];
    logic             w_carry_pipe [STAGES+1];
    logic             w_cmsb_pipe  [STAGES+1];
    logic             w_stall;

    assign w_valid_pipe[0] = in_valid;
    assign w_sum_pipe[0]   = '0;
    assign w_a_pipe[0]     = a;
    assign w_b_pipe[0]     = sub ? ~b : b;
    assign w_carry_pipe[0] = sub ? 1'b1 : cin;
    assign w_cmsb_pipe[0]  = 1'b0;

    assign w_stall   = w_valid_pipe[STAGES] & ~out_ready;
    assign in_ready  = ~w_stall;
    assign out_valid = w_valid_pipe[STAGES];

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int LSB = gi * SW;
        // Slices already summed are dropped from the operand registers; they fold to constants.
        localparam logic [WIDTH-1:0] HIGH_MASK = {WIDTH{1'b1}} << ((gi + 1) * SW);

        logic [SW-1:0]    w_slice_sum;
        logic             w_slice_cout;
        logic             w_slice_cmsb;
        logic [WIDTH-1:0] w_sum_next;

        logic             r_valid;
        logic [WIDTH-1:0] r_sum;
        logic [WIDTH-1:0] r_a;
        logic [WIDTH-1:0] r_b;
        logic             r_carry;
        logic             r_cmsb;

        adder_slice #(
            .W(SW)
        ) u_slice (
            .i_a    (w_a_pipe[gi][LSB +: SW]),
            .i_b    (w_b_pipe[gi][LSB +: SW]),
            .i_cin  (w_carry_pipe[gi]),
            .o_sum  (w_slice_sum),
            .o_cout (w_slice_cout),
            .o_cmsb (w_slice_cmsb)
        );

        always_comb begin
            w_sum_next              = w_sum_pipe[gi];
            w_sum_next[LSB +: SW]   = w_slice_sum;
        end

        // Bubbles advance like real data; the output gating hides their contents.
        always_ff @(posedge clk or negedge clear_n) begin
            if (!clear_n) begin
                r_valid <= 1'b0;
                r_sum   <= '0;
                r_a     <= '0;
                r_b     <= '0;
                r_carry <= 1'b0;
                r_cmsb  <= 1'b0;
            end else if (!w_stall) begin
                r_valid <= w_valid_pipe[gi];
                r_sum   <= w_sum_next;
                r_a     <= w_a_pipe[gi] & HIGH_MASK;
                r_b     <= w_b_pipe[gi] & HIGH_MASK;
                r_carry <= w_slice_cout;
                r_cmsb  <= w_slice_cmsb;
            end
        end

        assign w_valid_pipe[gi+1] = r_valid;
        assign w_sum_pipe[gi+1]   = r_sum;
        assign w_a_pipe[gi+1]     = r_a;
        assign w_b_pipe[gi+1]     = r_b;
        assign w_carry_pipe[gi+1] = r_carry;
        assign w_cmsb_pipe[gi+1]  = r_cmsb;
    end

    always_comb begin
        sum  = '0;
        cout = 1'b0;
        ovf  = 1'b0;
        zero = 1'b0;
        if (out_valid) begin
            sum  = w_sum_pipe[STAGES];
            cout = w_carry_pipe[STAGES];
            ovf  = w_cmsb_pipe[STAGES] ^ w_carry_pipe[STAGES];
            zero = (w_sum_pipe[STAGES] == '0);
        end
    end

endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: directed corner cases and random traffic on a
// two-stage instance, plus random traffic on one-, four- and eight-stage instances.
module tb_pipe_adder;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int last_acc_cyc = 0;
    int txn_n = 0;
    bit rnd_run = 1'b0;

    logic        clear_n, sw_clear_n;
    logic        in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf, zero;
    logic [31:0] a, b, sum;

    exp_t q[$];

    pipe_adder #(.WIDTH(32), .STAGES(2)) u_dut (
        .clk(clk), .clear_n(clear_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
    );

    // Reference: plain integer arithmetic; overflow = signed result does not fit in 32 bits.
    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic msub, input logic mcin);
        exp_t        e;
        logic [32:0] t;
        longint      sa, sb, sr;
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        if (!msub) begin
            t      = {1'b0, ma} + {1'b0, mb} + 33'(mcin);
            e.sum  = t[31:0];
            e.cout = t[32];
            sr     = sa + sb + longint'(mcin);
        end else begin
            e.sum  = ma - mb;
            e.cout = (ma >= mb);
            sr     = sa - sb;
        end
        e.ovf  = (sr != longint'($signed(e.sum)));
        e.zero = (e.sum == 32'd0);
        return e;
    endfunction

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h0000_FFFF;
            default: return $urandom();
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Present one operation and hold it until accepted; returns just after the accepting edge.
    task automatic send(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts, input logic tc);
        a = ta; b = tb_v; sub = ts; cin = tc; in_valid = 1'b1;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (in_ready) begin
                last_acc_cyc = cyc;
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL send_timeout: in_ready=%b for 64 cycles, required 1", in_ready);
        in_valid = 1'b0;
    endtask

    task automatic directed(input string name, input logic [31:0] ta, input logic [31:0] tb_v,
                            input logic ts, input logic tc, input logic [31:0] es,
                            input logic ec, input logic eo, input logic ez);
        bit found;
        found = 1'b0;
        out_ready = 1'b1;
        send(ta, tb_v, ts, tc);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (out_valid) begin found = 1'b1; break; end
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL %s: out_valid=0 for 10 cycles, required 1", name);
        end else begin
            check(name, 64'({sum, cout, ovf, zero}), 64'({es, ec, eo, ez}));
        end
        @(posedge clk); #1;
    endtask

    task automatic drain(input string name);
        bit empty;
        empty = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (q.size() == 0 && !out_valid) begin empty = 1'b1; break; end
        end
        if (!empty) begin
            checks++; errors++;
            $display("FAIL %s: %0d results still pending after 50 cycles, required 0", name, q.size());
        end
        @(posedge clk); #1;
    endtask

    // Input-side scoreboard feed.
    initial forever begin
        @(negedge clk);
        if (clear_n && in_valid && in_ready) q.push_back(model(a, b, sub, cin));
    end

    // Output monitor: ordered compare, idle-zero outputs, and stability while stalled.
    initial begin
        exp_t        e;
        bit          prev_stall;
        logic [34:0] prev_out;
        prev_stall = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clk);
            if (clear_n) begin
                if (prev_stall) begin
                    check("stall_hold_valid", 64'(out_valid), 64'(1'b1));
                    check("stall_hold_data", 64'({sum, cout, ovf, zero}), 64'(prev_out));
                end
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL scoreboard_extra: result sum=%h with nothing expected", sum);
                    end else begin
                        e = q.pop_front();
                        txn_n++;
                        $display("txn %0d: sum=%h cout=%b ovf=%b zero=%b (expected %h %b %b %b)",
                                 txn_n, sum, cout, ovf, zero, e.sum, e.cout, e.ovf, e.zero);
                        check("result", 64'({sum, cout, ovf, zero}), 64'(e));
                    end
                end else if (!out_valid) begin
                    check("idle_outputs_zero", 64'({sum, cout, ovf, zero}), 64'(0));
                end
                prev_stall = out_valid && !out_ready;
                prev_out   = {sum, cout, ovf, zero};
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // Independent random traffic on other depths.
    for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
        localparam int ST = (gi == 0) ? 1 : ((gi == 1) ? 4 : 8);
        logic        s_in_valid, s_in_ready, s_sub, s_cin, s_out_valid, s_out_ready;
        logic        s_cout, s_ovf, s_zero;
        logic [31:0] s_a, s_b, s_sum;
        bit          s_done = 1'b0;
        exp_t        s_q[$];

        pipe_adder #(.WIDTH(32), .STAGES(ST)) u_dut (
            .clk(clk), .clear_n(sw_clear_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
            .a(s_a), .b(s_b), .sub(s_sub), .cin(s_cin),
            .out_valid(s_out_valid), .out_ready(s_out_ready),
            .sum(s_sum), .cout(s_cout), .ovf(s_ovf), .zero(s_zero)
        );

        initial forever begin
            @(negedge clk);
            if (sw_clear_n && s_in_valid && s_in_ready) s_q.push_back(model(s_a, s_b, s_sub, s_cin));
        end

        initial begin
            exp_t e;
            forever begin
                @(negedge clk);
                if (sw_clear_n && s_out_valid && s_out_ready) begin
                    if (s_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL sweep%0d_extra: result sum=%h with nothing expected", ST, s_sum);
                    end else begin
                        e = s_q.pop_front();
                        check($sformatf("sweep%0d_result", ST), 64'({s_sum, s_cout, s_ovf, s_zero}), 64'(e));
                    end
                end
            end
        end

        initial begin
            bit empty;
            empty = 1'b0;
            s_in_valid = 1'b0; s_out_ready = 1'b0; s_a = '0; s_b = '0; s_sub = 1'b0; s_cin = 1'b0;
            wait (sw_clear_n);
            @(posedge clk); #1;
            for (int i = 0; i < 400; i++) begin
                s_a         = rand_op();
                s_b         = rand_op();
                s_sub       = 1'($urandom_range(0, 1));
                s_cin       = 1'($urandom_range(0, 1));
                s_in_valid  = ($urandom_range(0, 3) != 0);
                s_out_ready = ($urandom_range(0, 2) != 0);
                @(posedge clk); #1;
            end
            s_in_valid  = 1'b0;
            s_out_ready = 1'b1;
            for (int n = 0; n < 40; n++) begin
                @(negedge clk);
                if (s_q.size() == 0 && !s_out_valid) begin empty = 1'b1; break; end
            end
            check($sformatf("sweep%0d_drained", ST), 64'(empty), 64'(1'b1));
            s_done = 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t0;
        int  c0;
        bit  found;
        bit  all_done;
        clear_n = 1'b0; sw_clear_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_state", 64'({in_ready, out_valid, sum, cout, ovf, zero}), 64'({1'b1, 36'd0}));
        @(posedge clk); #1;
        clear_n = 1'b1; sw_clear_n = 1'b1;
        @(negedge clk);
        check("post_reset_ready", 64'({in_ready, out_valid}), 64'(2'b10));
        @(posedge clk); #1;

        // Boundary arithmetic
        directed("wrap_around",  32'hFFFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        directed("slice_carry",  32'h0000_FFFF, 32'h1,         1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        directed("pos_overflow", 32'h7FFF_FFFF, 32'h1,         1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        directed("neg_overflow", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        directed("add_cin",      32'h1,         32'h1,         1'b0, 1'b1, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
        directed("sub_borrow",   32'd5,         32'd7,         1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        directed("sub_equal",    32'd7,         32'd7,         1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        directed("sub_cin_ign",  32'd7,         32'd7,         1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        drain("directed_drain");

        // Six back-to-back increments: results in cycles 2..7, one per cycle
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 6; i++) send(32'h0, 32'h4, 1'b0, 1'b0);
            end
            begin
                @(negedge clk);
                @(negedge clk);
                check("inc_not_early", 64'(out_valid), 64'(1'b0));
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    check("inc_stream", 64'({out_valid, sum, cout}), 64'({1'b1, 32'h4, 1'b0}));
                end
                @(negedge clk);
                check("inc_end", 64'(out_valid), 64'(1'b0));
            end
        join
        drain("inc_drain");

        // Backpressure: 4 operations, consumer stalled for 3 cycles
        t0 = txn_n;
        out_ready = 1'b0;
        send(32'd10, 32'd1, 1'b0, 1'b0);
        send(32'd20, 32'd2, 1'b0, 1'b0);
        a = 32'd30; b = 32'd3; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'(1'b0));
            check("stall_out", 64'({out_valid, sum}), 64'({1'b1, 32'd11}));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(32'd30, 32'd3, 1'b0, 1'b0);
        send(32'd40, 32'd4, 1'b0, 1'b0);
        drain("stall_drain");
        check("stall_count", 64'(txn_n - t0), 64'(4));

        // Reset pulse with two operations in flight
        out_ready = 1'b1;
        send(32'd100, 32'd1, 1'b0, 1'b0);
        send(32'd200, 32'd2, 1'b0, 1'b0);
        #1;
        clear_n = 1'b0;
        q.delete();
        #1;
        check("rst_immediate", 64'({out_valid, sum, cout, ovf, zero}), 64'(0));
        #1;
        clear_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_stale", 64'({in_ready, out_valid}), 64'(2'b10));
        end
        @(posedge clk); #1;
        send(32'd300, 32'd3, 1'b0, 1'b0);
        c0 = last_acc_cyc;
        found = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (out_valid) begin found = 1'b1; break; end
        end
        check("rst_latency", 64'(found ? (cyc - c0) : -1), 64'(2));
        @(posedge clk); #1;
        drain("rst_drain");

        // Random operands with random consumer backpressure
        rnd_run = 1'b1;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    send(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                rnd_run = 1'b0;
            end
            begin
                while (rnd_run) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        drain("random_drain");

        all_done = 1'b0;
        for (int n = 0; n < 5000; n++) begin
            if (g_sweep[0].s_done && g_sweep[1].s_done && g_sweep[2].s_done) begin
                all_done = 1'b1;
                break;
            end
            @(posedge clk);
        end
        check("sweep_finished", 64'(all_done), 64'(1'b1));
        check("main_queue_empty", 64'(q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits; SHALL be a multiple of STAGES.
REQ-002 Parameter STAGES, default 2, number of pipeline stages and equal-width carry slices; range 1..8.
REQ-003 Port clk  input  1  master clock; all state changes on the rising edge.
REQ-004 Port clear_n  input  1  reset, asynchronous, active-low.
REQ-005 Port in_valid  input  1  operands valid this cycle.
REQ-006 Port in_ready  output  1  pipe accepts operands this cycle.
REQ-007 Port a  input  WIDTH  operand A.
REQ-008 Port b  input  WIDTH  operand B.
REQ-009 Port sub  input  1  mode: 0 = a+b+cin; 1 = a-b, computed as a+~b+1 with cin ignored.
REQ-010 Port cin  input  1  carry in, used only when sub=0.
REQ-011 Port out_valid  output  1  result fields valid.
REQ-012 Port out_ready  input  1  consumer accepts result this cycle.
REQ-013 Port sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-014 Port cout  output  1  carry out of MSB; when sub=1, 1 means no borrow.
REQ-015 Port ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
REQ-016 Port zero  output  1  sum == 0.

Function
REQ-017 Transfer in SHALL occur on a rising edge with in_valid=1 and in_ready=1; transfer out SHALL occur with out_valid=1 and out_ready=1.
REQ-018 Stage k (0..STAGES-1) SHALL add slice k of width WIDTH/STAGES, using the carry registered by stage k-1; stage 0 uses cin, or 1 when sub=1.
REQ-019 Each stage SHALL register its valid bit, the completed low slices, the unprocessed high slices of a and of ~b or b, its carry, and its MSB carry-in.
REQ-020 Latency SHALL be exactly STAGES cycles from transfer in to out_valid=1 when out_ready is held at 1.
REQ-021 Throughput SHALL be one operation per cycle when out_ready=1.
REQ-022 Stall condition SHALL be out_valid=1 and out_ready=0; in that case every stage holds and in_ready=0.
REQ-023 When there is no stall, in_ready=1 combinationally and all stages advance, including bubbles.
REQ-024 Results SHALL leave in acceptance order; none may be lost or duplicated under any out_ready pattern.
REQ-025 sum, cout, ovf and zero SHALL be stable while out_valid=1 and out_ready=0.
REQ-026 For STAGES=1 the block is a single registered full-width adder with latency 1.
REQ-027 Wrap-around: 0xFFFFFFFF+1 (WIDTH=32) SHALL give sum=0, cout=1, zero=1, ovf=0.
REQ-028 When out_valid=0, sum, cout, ovf and zero SHALL be driven 0.

Reset
REQ-029 clear_n=0 SHALL immediately clear all valid bits, data, carries and outputs to 0, at any time.
REQ-030 Operations in flight when clear_n falls SHALL be discarded, with no partial result presented.
REQ-031 After clear_n rises, in_ready=1 and out_valid=0; the first transfer in is possible on the first rising edge.

Structure
REQ-032 Package pipe_adder_pkg SHALL hold the WIDTH and STAGES defaults, the legal STAGES limit, and a SLICE_W constant function (WIDTH/STAGES).
REQ-033 A sub-module adder_slice (SLICE_W-bit combinational full adder with cin, cout and MSB carry-in) SHALL be instantiated once per stage.
REQ-034 An elaboration-time check SHALL fail when WIDTH mod STAGES is non-zero or STAGES is outside 1..8.

Verification (WIDTH=32, STAGES=2 unless stated)
REQ-035 Increment: a=0x00000000, b=0x00000004, sub=0 for 6 consecutive cycles, out_ready=1 -> sum=0x00000004 from cycle 2, one result per cycle, cout=0.
REQ-036 Slice carry: a=0x0000FFFF, b=0x00000001 -> sum=0x00010000, cout=0, ovf=0; and a=0x7FFFFFFF, b=1 -> sum=0x80000000, ovf=1.
REQ-037 Subtract: sub=1, a=5, b=7 -> sum=0xFFFFFFFE, cout=0; then a=7, b=7 -> sum=0, zero=1, cout=1.
REQ-038 Backpressure: 4 back-to-back operations with out_ready=0 for 3 cycles -> in_ready=0 while stalled, outputs held, all 4 results delivered in order.
REQ-039 Reset mid-operation: clear_n pulsed low between edges with 2 operations in flight -> out_valid=0 immediately, no stale result afterwards, and a new operation completes with latency 2.
REQ-040 Parameter sweep: STAGES in {1,4,8} with random operands and random out_ready -> every result matches the reference model a+b+cin or a-b.
